// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency instruction ROM,
// and delivers {inst, pc} words to decode with redirect, stall-skid and halt handling.
module fetch_stage #(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       INST_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [INST_W-1:0]        imem_rdata,
  input  logic                     stall,
  input  logic                     do_branch,
  input  logic [ADDR_W-1:0]        branch_address,
  input  logic                     do_jump,
  input  logic [ADDR_W-1:0]        jump_address,
  output logic [INST_W+ADDR_W-1:0] to_inst,
  output logic                     inst_valid,
  output logic                     halted
);

  typedef enum logic {S_RUN, S_HALTED} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                req_valid_q, req_valid_d;
  logic [ADDR_W-1:0]   req_pc_q, req_pc_d;
  logic                skid_valid_q, skid_valid_d;
  logic [INST_W-1:0]   skid_inst_q, skid_inst_d;
  logic [ADDR_W-1:0]   skid_pc_q, skid_pc_d;
  logic                out_valid_q, out_valid_d;
  logic [INST_W-1:0]   out_inst_q, out_inst_d;
  logic [ADDR_W-1:0]   out_pc_q, out_pc_d;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_valid_d  = req_valid_q;
    req_pc_d     = req_pc_q;
    skid_valid_d = skid_valid_q;
    skid_inst_d  = skid_inst_q;
    skid_pc_d    = skid_pc_q;
    out_valid_d  = out_valid_q;
    out_inst_d   = out_inst_q;
    out_pc_d     = out_pc_q;

    if (do_branch || do_jump) begin
      pc_d         = do_branch ? branch_address : jump_address;
      req_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      out_valid_d  = 1'b0;
      out_inst_d   = '0;
      out_pc_d     = '0;
      state_d      = S_RUN;
    end else if (state_q == S_HALTED) begin
      req_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (stall) begin
      // PC is frozen while stalled, so at most the one in-flight word lands here.
      req_valid_d = 1'b0;
      if (req_valid_q) begin
        skid_valid_d = 1'b1;
        skid_inst_d  = imem_rdata;
        skid_pc_d    = req_pc_q;
      end
    end else begin
      pc_d         = pc_q + ADDR_W'(1);
      req_valid_d  = 1'b1;
      req_pc_d     = pc_q;
      skid_valid_d = 1'b0;
      if (skid_valid_q) begin
        out_valid_d = 1'b1;
        out_inst_d  = skid_inst_q;
        out_pc_d    = skid_pc_q;
      end else if (req_valid_q) begin
        out_valid_d = 1'b1;
        out_inst_d  = imem_rdata;
        out_pc_d    = req_pc_q;
      end else begin
        out_valid_d = 1'b0;
        out_inst_d  = '0;
        out_pc_d    = '0;
      end
      if (out_valid_d && (out_inst_d[INST_W-1 -: 4] == 4'b1111)) begin
        state_d = S_HALTED;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_RUN;
      pc_q         <= RESET_PC;
      req_valid_q  <= 1'b0;
      req_pc_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_inst_q  <= '0;
      skid_pc_q    <= '0;
      out_valid_q  <= 1'b0;
      out_inst_q   <= '0;
      out_pc_q     <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_valid_q  <= req_valid_d;
      req_pc_q     <= req_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_inst_q  <= skid_inst_d;
      skid_pc_q    <= skid_pc_d;
      out_valid_q  <= out_valid_d;
      out_inst_q   <= out_inst_d;
      out_pc_q     <= out_pc_d;
    end
  end

  assign imem_addr  = pc_q;
  assign to_inst    = {out_inst_q, out_pc_q};
  assign inst_valid = out_valid_q;
  assign halted     = (state_q == S_HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: two instances (RESET_PC 0000 and FFFF) share one ROM image and
// stimulus; outputs are compared against a word-stream model of the fetch behaviour.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        do_branch;
  logic [15:0] branch_address;
  logic        do_jump;
  logic [15:0] jump_address;

  logic [15:0] imem_addr  [2];
  logic [15:0] imem_rdata [2];
  logic [31:0] to_inst    [2];
  logic        inst_valid [2];
  logic        halted     [2];

  logic [15:0] mem [65536];

  int checks   = 0;
  int failures = 0;

  // Stream model: next pc to deliver, bubbles still owed before it, halt flag, output word.
  logic [15:0] m_pc   [2];
  int          m_pend [2];
  bit          m_halt [2];
  logic [31:0] m_out  [2];
  bit          m_val  [2];

  fetch_stage #(.ADDR_W(16), .INST_W(16), .RESET_PC(16'h0000)) dut0 (
    .clk(clk), .rst(rst), .imem_addr(imem_addr[0]), .imem_rdata(imem_rdata[0]),
    .stall(stall), .do_branch(do_branch), .branch_address(branch_address),
    .do_jump(do_jump), .jump_address(jump_address),
    .to_inst(to_inst[0]), .inst_valid(inst_valid[0]), .halted(halted[0])
  );

  fetch_stage #(.ADDR_W(16), .INST_W(16), .RESET_PC(16'hFFFF)) dut1 (
    .clk(clk), .rst(rst), .imem_addr(imem_addr[1]), .imem_rdata(imem_rdata[1]),
    .stall(stall), .do_branch(do_branch), .branch_address(branch_address),
    .do_jump(do_jump), .jump_address(jump_address),
    .to_inst(to_inst[1]), .inst_valid(inst_valid[1]), .halted(halted[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    imem_rdata[0] <= mem[imem_addr[0]];
    imem_rdata[1] <= mem[imem_addr[1]];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input int i);
    logic [15:0] w;
    if (rst) begin
      m_pc[i] = (i == 0) ? 16'h0000 : 16'hFFFF;
      m_pend[i] = 1; m_halt[i] = 0; m_out[i] = '0; m_val[i] = 0;
    end else if (do_branch || do_jump) begin
      m_pc[i] = do_branch ? branch_address : jump_address;
      m_pend[i] = 1; m_halt[i] = 0; m_out[i] = '0; m_val[i] = 0;
    end else if (m_halt[i] || stall) begin
      // nothing moves
    end else if (m_pend[i] > 0) begin
      m_pend[i]--; m_out[i] = '0; m_val[i] = 0;
    end else begin
      w = mem[m_pc[i]];
      m_out[i] = {w, m_pc[i]};
      m_val[i] = 1;
      m_halt[i] = (w[15:12] == 4'hF);
      m_pc[i] = m_pc[i] + 16'd1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("to_inst%0d", i), to_inst[i], m_out[i]);
      check_eq($sformatf("inst_valid%0d", i), {31'd0, inst_valid[i]}, {31'd0, m_val[i]});
      check_eq($sformatf("halted%0d", i), {31'd0, halted[i]}, {31'd0, m_halt[i]});
    end
  endtask

  task automatic check_word(input string tag, input int i, input logic [31:0] exp, input bit v);
    check_eq({tag, "_word"}, to_inst[i], exp);
    check_eq({tag, "_valid"}, {31'd0, inst_valid[i]}, {31'd0, v});
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; do_branch = 1'b0; do_jump = 1'b0;
    branch_address = '0; jump_address = '0;
    for (int i = 0; i < 2; i++) begin
      m_pc[i] = '0; m_pend[i] = 1; m_halt[i] = 0; m_out[i] = '0; m_val[i] = 0;
    end
    for (int unsigned a = 0; a < 65536; a++) mem[a] = '0;
    mem[16'h0000] = 16'h1123; mem[16'h0001] = 16'h2456;
    mem[16'h0002] = 16'h5A07; mem[16'h0003] = 16'h7100;
    mem[16'h0004] = 16'hF000; mem[16'h0010] = 16'h3ABC;
    mem[16'h0020] = 16'h1234; mem[16'h0030] = 16'h4321;
    mem[16'h0040] = 16'h2222; mem[16'hFFFF] = 16'h6EEE;

    // Reset and sequential run
    cycle(); cycle();
    check_word("reset", 0, 32'h0, 1'b0);
    rst = 1'b0;
    cycle();
    check_word("first_bubble", 0, 32'h0, 1'b0);
    cycle();
    check_word("seq0", 0, 32'h1123_0000, 1'b1);
    check_word("wrap_ffff", 1, 32'h6EEE_FFFF, 1'b1);
    cycle();
    check_word("seq1", 0, 32'h2456_0001, 1'b1);
    check_word("wrap_0000", 1, 32'h1123_0000, 1'b1);

    // Stall with skid
    stall = 1'b1;
    repeat (3) begin
      cycle();
      check_word("stall_hold", 0, 32'h2456_0001, 1'b1);
    end
    stall = 1'b0;
    cycle();
    check_word("seq2", 0, 32'h5A07_0002, 1'b1);
    cycle();
    check_word("seq3", 0, 32'h7100_0003, 1'b1);

    // Halt park, stall ignored while parked
    cycle();
    check_word("halt_word", 0, 32'hF000_0004, 1'b1);
    check_eq("halt_flag", {31'd0, halted[0]}, 32'd1);
    for (int k = 0; k < 10; k++) begin
      stall = (k % 3 == 1);
      cycle();
      check_word("halt_hold", 0, 32'hF000_0004, 1'b1);
    end
    stall = 1'b0;

    // Branch exits halt
    do_branch = 1'b1; branch_address = 16'h0010;
    cycle();
    check_word("br_bubble0", 0, 32'h0, 1'b0);
    check_eq("halt_exit", {31'd0, halted[0]}, 32'd0);
    do_branch = 1'b0;
    cycle();
    check_word("br_bubble1", 0, 32'h0, 1'b0);
    cycle();
    check_word("br_target", 0, 32'h3ABC_0010, 1'b1);

    // Branch beats jump
    do_branch = 1'b1; branch_address = 16'h0020;
    do_jump = 1'b1; jump_address = 16'h0030;
    cycle();
    do_branch = 1'b0; do_jump = 1'b0;
    cycle(); cycle();
    check_word("br_over_jmp", 0, 32'h1234_0020, 1'b1);

    // Redirect overrides stall and drops the skid word
    stall = 1'b1;
    cycle(); cycle();
    do_jump = 1'b1; jump_address = 16'h0040;
    cycle();
    check_word("jmp_stall_bubble", 0, 32'h0, 1'b0);
    do_jump = 1'b0; stall = 1'b0;
    cycle(); cycle();
    check_word("jmp_target", 0, 32'h2222_0040, 1'b1);

    // Mid-stream reset; ROM reloaded with random contents while reset is held
    rst = 1'b1;
    cycle();
    check_word("mid_reset", 0, 32'h0, 1'b0);
    for (int unsigned a = 0; a < 65536; a++) mem[a] = 16'($urandom);
    cycle();
    rst = 1'b0;

    for (int n = 0; n < 3000; n++) begin
      rst            = ($urandom_range(99) < 2);
      stall          = ($urandom_range(99) < 25);
      do_branch      = ($urandom_range(99) < 6);
      do_jump        = ($urandom_range(99) < 6);
      branch_address = 16'($urandom);
      jump_address   = 16'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage: owns the program counter and drives the synchronous instruction ROM.
- Presents one Inst word ({inst, pc}) per cycle to the decode stage.
- Handles redirects: do_branch from execute, do_jump from decode.
- Handles load-use stalls with a 1-entry skid buffer, and parks on a fetched halt instruction.

Parameters:
- RESET_PC, 16'h0000, first fetch address after reset.
- ADDR_W, 16, PC / ROM address width.
- INST_W, 16, instruction width; opcode is bits [15:12].

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset; sampled on posedge clk.
- imem_addr  output  ADDR_W  ROM read address; always equals pc_q.
- imem_rdata  input  INST_W  ROM data for the address presented in the previous cycle (1-cycle latency).
- stall  input  1  decode cannot accept a new word; hold the output.
- do_branch  input  1  execute-stage taken branch.
- branch_address  input  ADDR_W  absolute branch target.
- do_jump  input  1  decode-stage jump.
- jump_address  input  ADDR_W  absolute jump target.
- to_inst  output  INST_W+ADDR_W  Inst to decode: [31:16] inst, [15:0] pc.
- inst_valid  output  1  to_inst holds a real fetched word (0 = bubble).
- halted  output  1  stage is parked on a halt instruction.

Behaviour:
- State: pc_q, req_valid_q, req_pc_q, skid {valid, inst, pc}, out register, FSM {RUN, HALTED}.
- Reset (rst high at edge):
  - pc_q=RESET_PC, req_valid_q=0, skid empty, to_inst=0, inst_valid=0, halted=0, state RUN.
  - Reset mid-operation discards everything, including in-flight ROM data.
- Event priority at each edge: rst > do_branch > do_jump > stall > normal advance.
- Normal (RUN, no stall, no redirect):
  - pc_q <= pc_q+1, wrapping 16'hFFFF -> 16'h0000.
  - req_valid_q <= 1; req_pc_q <= pc_q.
  - If skid.valid: out <= skid and skid is cleared. Else if req_valid_q: out <= {imem_rdata, req_pc_q}, inst_valid=1. Else: out <= bubble (inst 0, pc 0, inst_valid 0).
  - Throughput is 1 word per cycle.
- Stall (RUN, stall=1, no redirect):
  - pc_q, out and inst_valid hold; req_valid_q <= 0.
  - If req_valid_q is set, {imem_rdata, req_pc_q} is captured into skid.
  - The skid never overflows: pc is frozen, so at most one word is in flight.
  - Re-reads of pc_q during a stall are ignored.
- Redirect (do_branch or do_jump):
  - pc_q <= target (branch_address when both asserted); out <= bubble; skid cleared; req_valid_q <= 0.
  - The in-flight word is squashed.
  - Stall is ignored on the redirect edge.
  - Redirect sampled at edge E: bubble after E and E+1; mem[target] in to_inst with inst_valid=1 after E+2.
- Reset release: if rst is last high at edge E0, mem[RESET_PC] appears after E0+2.
- Halt:
  - When the word loaded into out has opcode 4'b1111, the FSM goes to HALTED and halted=1.
  - While HALTED: pc_q frozen, req_valid_q=0, skid cleared; to_inst keeps the halt word and inst_valid stays 1.
  - stall is ignored in HALTED.
  - Exits only via rst or a redirect; a redirect behaves as above and returns to RUN with halted=0 on that edge.
  - A halt word sitting in skid does not halt until it moves into out.
- Opcode 4'b0000 words are passed through as ordinary valid words; bubbles are distinguished only by inst_valid=0.

Test Plan:
- Sequential run: ROM[0..3] = 1123, 2456, 5A07, 7100; release reset -> to_inst = {1123,0000},{2456,0001},{5A07,0002},{7100,0003} on consecutive cycles; inst_valid = 0,0,1,1,1,1.
- Stall with skid: stall held 3 cycles while out={2456,0001} -> out holds; after release out={5A07,0002} then {7100,0003}, with no word lost or duplicated.
- Branch redirect: do_branch=1, branch_address=0010 at edge E, ROM[10]=3ABC -> bubbles after E and E+1, {3ABC,0010} after E+2.
- Branch and jump together: branch_address=0020, jump_address=0030 -> fetch resumes at 0020.
- Redirect overrides stall: do_jump with stall=1 -> skid cleared, fetch resumes at jump_address.
- Halt park/exit: ROM[4]=F000 -> halted=1 and to_inst holds {F000,0004} for 10 cycles; do_branch to 0000 -> halted=0, ROM[0] appears 2 edges later.
- Wrap and reset: RESET_PC=FFFF -> pcs FFFF then 0000; rst pulse mid-stream -> to_inst=0, inst_valid=0 on the next edge.
